nibble_state_reader: RTL and testbench
======================================

# nibble_state_reader

Read side of the nibble-written 8-bit state register. The block watches the register value every clock, detects which half changed (bits [0:3] or bits [4:7]), and queues each change as a nibble-update record. Records leave in order over a VALID/READY handshake to a downstream consumer such as a status serializer or a host read port. Overflow is flagged, never silent.

## Interface
- DEPTH, 4, number of FIFO record slots; power of two, minimum 2.
- CLOCK  input  1  rising-edge clock for all state.
- RST_N  input  1  synchronous reset, active-low.
- STATE_IN  input  [0:7]  monitored register value, synchronous to CLOCK.
- OUT_READY  input  1  consumer accepts the head record this cycle.
- CLEAR_OVF  input  1  clears OVERFLOW at the next edge.
- OUT_VALID  output  1  head record present.
- OUT_SEL  output  1  1 = record is nibble [0:3]; 0 = record is nibble [4:7].
- OUT_NIBBLE  output  [0:3]  nibble value captured at detection.
- OUT_COUNT  output  clog2(DEPTH)+1  records currently stored.
- OVERFLOW  output  1  sticky; a record was dropped.

## Operation
- PREV register [0:7] holds the STATE_IN value from the previous edge. It is loaded with STATE_IN at every non-reset edge, including edges where records are dropped.
- Detection at each edge: hiChg = (STATE_IN[0:3] != PREV[0:3]); loChg = (STATE_IN[4:7] != PREV[4:7]).
- Record format: {SEL, NIBBLE}. The hi record is {1, STATE_IN[0:3]}. The lo record is {0, STATE_IN[4:7]}.
- Push order when both halves change: hi record first, then lo record. The block pushes up to 2 records per edge.
- Pop: the head is removed at an edge where OUT_VALID and OUT_READY are both 1.
- Free space at an edge = DEPTH − OUT_COUNT + pop. A same-cycle pop frees its slot for that edge's pushes.
- Space check for hi is done first:
  - If space ≥ needed, all records are pushed.
  - If space = 1 and both halves changed, hi is pushed and lo is dropped.
  - If space = 0, every detected record is dropped.
  - Any drop sets OVERFLOW.
- OVERFLOW stays 1 until an edge with CLEAR_OVF = 1 and no new drop. If a drop and CLEAR_OVF occur on the same edge, the drop wins and OVERFLOW = 1.
- FIFO is show-ahead: OUT_SEL and OUT_NIBBLE always show the head slot. Both are don't-care while OUT_VALID = 0; the bench masks them.
- Read and write pointers wrap modulo DEPTH. OUT_COUNT = pushes − pops and is never greater than DEPTH.

## Timing
- Reset (RST_N = 0 at an edge) loads:
  - PREV = 8'h00, matching the reset value of the written register.
  - OUT_COUNT = 0, OUT_VALID = 0, OVERFLOW = 0, pointers = 0.
  - OUT_SEL = 0, OUT_NIBBLE = 0.
- While RST_N = 0, no detection and no push happen. OUT_READY and CLEAR_OVF are ignored.
- First edge after reset release: STATE_IN is compared against 8'h00. A nonzero value produces records.
- Latency: the value is present on STATE_IN before edge k; the record is pushed at edge k; OUT_VALID = 1 after edge k if the FIFO was empty. This is 1 cycle.
- Throughput: 1 pop per cycle sustained, and 2 pushes per cycle peak.
- Handshake:
  - Once OUT_VALID is 1, it stays 1 and the head holds steady until popped.
  - OUT_READY may be high while OUT_VALID is 0; nothing happens.
  - OUT_VALID never depends combinationally on OUT_READY.
- Full FIFO with OUT_READY = 1 and one change: pop and push happen on the same edge, and OUT_COUNT stays at DEPTH.
- Reset mid-stream: all queued records are discarded at that edge, with no partial output.
- Registered outputs: OUT_VALID, OUT_COUNT and OVERFLOW are registered. OUT_SEL and OUT_NIBBLE come from the storage read mux.

## Test plan
- Reset then idle: release RST_N with STATE_IN = 8'h00 held for 10 cycles -> OUT_VALID = 0, OUT_COUNT = 0, OVERFLOW = 0 throughout.
- Single-half changes, OUT_READY = 1:
  - Drive STATE_IN = 8'hA0, then 8'hA5 -> record {1, 4'hA} one cycle after the first change, then {0, 4'h5}.
  - Each record holds OUT_VALID for exactly 1 cycle.
- Both halves change at once: STATE_IN goes 8'h00 -> 8'h3C with OUT_READY = 0 -> OUT_COUNT = 2; after OUT_READY rises, records appear in order {1, 4'h3} then {0, 4'hC}.
- Overflow, DEPTH = 4, OUT_READY = 0:
  - Apply 8'h11, 8'h22, 8'h33 on successive cycles, giving 6 records against 4 slots -> OUT_COUNT = 4 and OVERFLOW = 1.
  - Queue holds {1,1},{0,1},{1,2},{0,2}.
  - Pulse CLEAR_OVF -> OVERFLOW = 0.
- Full FIFO, concurrent pop and push: with 4 records queued, assert OUT_READY and change STATE_IN[0:3] only on the same edge -> OUT_COUNT stays 4, OVERFLOW stays 0, new record at the tail.
- Reset mid-operation: with 3 records queued, drive RST_N = 0 for 1 cycle while STATE_IN = 8'hFF -> OUT_COUNT = 0 and OUT_VALID = 0; after release, two records {1, F}, {0, F} appear, because PREV was reset to 00.

Source files
------------

// File: rtl/nibble_state_reader.sv
// Read side of the nibble-written state register: detects which half changed
// and queues {sel, nibble} records for a valid/ready consumer.
module nibble_state_reader #(
    parameter int DEPTH = 4
) (
    input  logic                     CLOCK,
    input  logic                     RST_N,
    input  logic [0:7]               STATE_IN,
    input  logic                     OUT_READY,
    input  logic                     CLEAR_OVF,
    output logic                     OUT_VALID,
    output logic                     OUT_SEL,
    output logic [0:3]               OUT_NIBBLE,
    output logic [$clog2(DEPTH):0]   OUT_COUNT,
    output logic                     OVERFLOW
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]    mem [DEPTH];
    logic [0:7]    prev;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          valid_q;
    logic          ovf_q;

    logic          hi_chg;
    logic          lo_chg;
    logic          pop;
    logic [CW-1:0] space;
    logic          push_hi;
    logic          push_lo;
    logic          drop;
    logic [CW-1:0] n_push;
    logic [CW-1:0] count_nxt;
    logic [AW-1:0] lo_slot;

    always_comb begin
        hi_chg    = 1'b0;
        lo_chg    = 1'b0;
        pop       = 1'b0;
        space     = '0;
        push_hi   = 1'b0;
        push_lo   = 1'b0;
        drop      = 1'b0;
        n_push    = '0;
        count_nxt = count;
        lo_slot   = wr_ptr;

        hi_chg  = (STATE_IN[0:3] != prev[0:3]);
        lo_chg  = (STATE_IN[4:7] != prev[4:7]);
        pop     = valid_q & OUT_READY;
        // a same-edge pop frees its slot for this edge's pushes
        space   = CW'(DEPTH) - count + CW'(pop);
        push_hi = hi_chg && (space >= CW'(1));
        push_lo = lo_chg && (space >= (hi_chg ? CW'(2) : CW'(1)));
        drop    = (hi_chg && !push_hi) || (lo_chg && !push_lo);
        n_push  = CW'(push_hi) + CW'(push_lo);
        count_nxt = count + n_push - CW'(pop);
        lo_slot = push_hi ? wr_ptr + AW'(1) : wr_ptr;
    end

    always_ff @(posedge CLOCK) begin
        if (!RST_N) begin
            prev    <= 8'h00;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            prev    <= STATE_IN;
            wr_ptr  <= wr_ptr + AW'(n_push);
            rd_ptr  <= rd_ptr + AW'(pop);
            count   <= count_nxt;
            valid_q <= (count_nxt != '0);
            if (drop)
                ovf_q <= 1'b1;
            else if (CLEAR_OVF)
                ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RST_N) begin
            if (push_hi)
                mem[wr_ptr] <= {1'b1, STATE_IN[0:3]};
            if (push_lo)
                mem[lo_slot] <= {1'b0, STATE_IN[4:7]};
        end
    end

    // head is masked to zero while empty so reset shows a clean record
    assign OUT_VALID  = valid_q;
    assign OUT_SEL    = valid_q ? mem[rd_ptr][4] : 1'b0;
    assign OUT_NIBBLE = valid_q ? mem[rd_ptr][3:0] : 4'h0;
    assign OUT_COUNT  = count;
    assign OVERFLOW   = ovf_q;

endmodule

// File: tb/tb_nibble_state_reader.sv
// Directed bench for nibble_state_reader (DEPTH = 4) with
// hand-computed expectations checked by immediate assertions.
module tb_nibble_state_reader;

    logic       CLOCK;
    logic       RST_N;
    logic [0:7] STATE_IN;
    logic       OUT_READY;
    logic       CLEAR_OVF;
    logic       OUT_VALID;
    logic       OUT_SEL;
    logic [0:3] OUT_NIBBLE;
    logic [2:0] OUT_COUNT;
    logic       OVERFLOW;

    int checks = 0;
    int errors = 0;

    nibble_state_reader #(.DEPTH(4)) dut (
        .CLOCK      (CLOCK),
        .RST_N      (RST_N),
        .STATE_IN   (STATE_IN),
        .OUT_READY  (OUT_READY),
        .CLEAR_OVF  (CLEAR_OVF),
        .OUT_VALID  (OUT_VALID),
        .OUT_SEL    (OUT_SEL),
        .OUT_NIBBLE (OUT_NIBBLE),
        .OUT_COUNT  (OUT_COUNT),
        .OVERFLOW   (OVERFLOW)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic v,
                          input logic [2:0] c, input logic o);
        chk({tag, ".valid"}, {7'd0, OUT_VALID}, {7'd0, v});
        chk({tag, ".count"}, {5'd0, OUT_COUNT}, {5'd0, c});
        chk({tag, ".ovf"}, {7'd0, OVERFLOW}, {7'd0, o});
    endtask

    task automatic chk_hd(input string tag, input logic s,
                          input logic [3:0] n);
        chk({tag, ".head"}, {3'd0, OUT_SEL, OUT_NIBBLE}, {3'd0, s, n});
    endtask

    initial begin
        RST_N     = 1'b0;
        STATE_IN  = 8'h00;
        OUT_READY = 1'b0;
        CLEAR_OVF = 1'b0;
        step();
        step();
        chk_st("reset", 1'b0, 3'd0, 1'b0);
        chk_hd("reset", 1'b0, 4'h0);

        RST_N = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk_st("idle", 1'b0, 3'd0, 1'b0);
        end

        OUT_READY = 1'b1;
        STATE_IN  = 8'hA0;
        step();
        chk_st("hiA", 1'b1, 3'd1, 1'b0);
        chk_hd("hiA", 1'b1, 4'hA);
        STATE_IN = 8'hA5;
        step();
        chk_st("lo5", 1'b1, 3'd1, 1'b0);
        chk_hd("lo5", 1'b0, 4'h5);
        step();
        chk_st("drain1", 1'b0, 3'd0, 1'b0);

        OUT_READY = 1'b0;
        STATE_IN  = 8'h00;
        step();
        chk_st("back00", 1'b1, 3'd2, 1'b0);
        OUT_READY = 1'b1;
        step();
        step();
        chk_st("drain2", 1'b0, 3'd0, 1'b0);

        OUT_READY = 1'b0;
        STATE_IN  = 8'h3C;
        step();
        chk_st("both3C", 1'b1, 3'd2, 1'b0);
        chk_hd("both3C.1", 1'b1, 4'h3);
        step();
        chk_st("hold3C", 1'b1, 3'd2, 1'b0);
        chk_hd("hold3C", 1'b1, 4'h3);
        OUT_READY = 1'b1;
        step();
        chk_st("pop3C", 1'b1, 3'd1, 1'b0);
        chk_hd("both3C.2", 1'b0, 4'hC);
        step();
        chk_st("drain3", 1'b0, 3'd0, 1'b0);

        OUT_READY = 1'b0;
        STATE_IN  = 8'h11;
        step();
        chk_st("ov11", 1'b1, 3'd2, 1'b0);
        STATE_IN = 8'h22;
        step();
        chk_st("ov22", 1'b1, 3'd4, 1'b0);
        STATE_IN = 8'h33;
        step();
        chk_st("ov33", 1'b1, 3'd4, 1'b1);
        chk_hd("ov33", 1'b1, 4'h1);
        step();
        chk_st("ovsticky", 1'b1, 3'd4, 1'b1);
        CLEAR_OVF = 1'b1;
        step();
        CLEAR_OVF = 1'b0;
        chk_st("clr", 1'b1, 3'd4, 1'b0);

        OUT_READY = 1'b1;
        STATE_IN  = 8'h43;
        step();
        chk_st("fullpp", 1'b1, 3'd4, 1'b0);
        chk_hd("q1", 1'b0, 4'h1);
        step();
        chk_hd("q2", 1'b1, 4'h2);
        chk_st("q2", 1'b1, 3'd3, 1'b0);
        step();
        chk_hd("q3", 1'b0, 4'h2);
        step();
        chk_hd("q4", 1'b1, 4'h4);
        chk_st("q4", 1'b1, 3'd1, 1'b0);
        step();
        chk_st("drain4", 1'b0, 3'd0, 1'b0);

        OUT_READY = 1'b0;
        STATE_IN  = 8'h53;
        step();
        STATE_IN = 8'h54;
        step();
        STATE_IN = 8'h64;
        step();
        chk_st("pre_rst", 1'b1, 3'd3, 1'b0);
        RST_N     = 1'b0;
        OUT_READY = 1'b1;
        STATE_IN  = 8'hFF;
        step();
        chk_st("mid_rst", 1'b0, 3'd0, 1'b0);
        RST_N     = 1'b1;
        OUT_READY = 1'b0;
        step();
        chk_st("post_rst", 1'b1, 3'd2, 1'b0);
        chk_hd("postF.1", 1'b1, 4'hF);
        OUT_READY = 1'b1;
        step();
        chk_hd("postF.2", 1'b0, 4'hF);
        step();
        chk_st("drain5", 1'b0, 3'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
